// File: rtl/manchester_encoder_if.sv
// Word handshake between the LED command framer (master) and the
// Manchester encoder (slave).
interface manchester_encoder_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/manchester_encoder.sv
// Manchester line encoder: takes parallel words over a valid/ready handshake
// and serialises each one MSB-first behind an alternating 1,0,1,0 preamble
// so the far-end decoder can lock its recovered clock.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line parked at IDLE_LEVEL, ready for a word
// S_PRE    | sending preamble bits 1,0,1,0,...
// S_DATA   | sending payload bits MSB-first from the shift register
module manchester_encoder #(
    parameter int HALF_BIT_CLKS = 8,
    parameter int DATA_W        = 8,
    parameter int PRE_BITS      = 4,
    parameter int IEEE_POL      = 1,
    parameter int IDLE_LEVEL    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    manchester_encoder_if.slave  tx_if,
    output logic                 man_out,
    output logic                 bal_clk,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // A frame without preamble starts directly in the data phase.
    localparam logic [1:0] S_START = (PRE_BITS > 0) ? S_PRE : S_DATA;

    localparam int MAX_BITS = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
    localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int HB_W     = $clog2(HALF_BIT_CLKS);

    localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HALF_BIT_CLKS - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    localparam logic IDLE_LVL = (IDLE_LEVEL != 0);
    // G.E. Thomas polarity is the IEEE waveform inverted.
    localparam logic POL_INV  = (IEEE_POL == 0);

    logic [1:0]        state_q,   state_d;
    logic [HB_W-1:0]   hb_cnt_q,  hb_cnt_d;
    logic              half_q,    half_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic              man_out_q, man_out_d;
    logic              bal_clk_q, bal_clk_d;

    logic hb_end;
    logic bit_end;
    logic last_clk;
    logic accept;
    logic tx_ready_int;
    logic cur_bit_d;

    // Boundary detection on the current counter values.
    always_comb begin
        hb_end       = (hb_cnt_q == HB_LAST);
        bit_end      = hb_end && half_q;
        last_clk     = (state_q == S_DATA) && bit_end && (bit_cnt_q == DATA_LAST);
        // Ready on the final clk of a frame lets the next word follow with no gap.
        tx_ready_int = (state_q == S_IDLE) || last_clk;
        accept       = tx_if.tx_valid && tx_ready_int;
    end

    // Next-state, counter and shift-register update; an accept overrides all.
    always_comb begin
        state_d   = state_q;
        hb_cnt_d  = hb_cnt_q;
        half_d    = half_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;

        if (state_q != S_IDLE) begin
            if (hb_end) begin
                hb_cnt_d = '0;
                half_d   = ~half_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end

            if (bit_end) begin
                case (state_q)
                    S_PRE: begin
                        if (bit_cnt_q == PRE_LAST) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                    S_DATA: begin
                        shift_d = shift_q << 1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d   = S_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                    default: begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end
                endcase
            end
        end

        if (accept) begin
            state_d   = S_START;
            hb_cnt_d  = '0;
            half_d    = 1'b0;
            bit_cnt_d = '0;
            shift_d   = tx_if.tx_data;
        end
    end

    // Line level for the next cycle, so man_out is a clean register output.
    always_comb begin
        cur_bit_d = (state_d == S_PRE) ? ~bit_cnt_d[0] : shift_d[DATA_W-1];
        if (state_d == S_IDLE) begin
            man_out_d = IDLE_LVL;
            bal_clk_d = 1'b0;
        end else begin
            // IEEE: first half carries ~bit, second half carries bit.
            man_out_d = cur_bit_d ^ ~half_d ^ POL_INV;
            bal_clk_d = ~half_d;
        end
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hb_cnt_q  <= '0;
            half_q    <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            man_out_q <= IDLE_LVL;
            bal_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hb_cnt_q  <= hb_cnt_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            man_out_q <= man_out_d;
            bal_clk_q <= bal_clk_d;
        end
    end

    assign tx_if.tx_ready = tx_ready_int;
    assign man_out        = man_out_q;
    assign bal_clk        = bal_clk_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = last_clk;

endmodule
